// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// with sticky flags for missing write acks and FIFO overflow.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         o_fifo_data_in,
    input  logic                          i_fifo_full,
    input  logic                          i_fifo_wr_ack,
    input  logic                          i_fifo_overflow,
    input  logic                          i_err_clr,
    output logic                          o_gnt_active,
    output logic [$clog2(NUM_REQ)-1:0]    o_gnt_id,
    output logic                          o_err_drop,
    output logic                          o_err_ovf
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t            r_state, w_state_nxt;
    logic [IW-1:0]     r_gnt_id, r_ptr, w_gnt_nxt, w_ptr_nxt, w_gnt_inc, w_from, w_off, w_pick;
    logic [IW:0]       w_sum;
    logic [2*NUM_REQ-1:0] w_rot;
    logic [BW-1:0]     r_beats, w_beats_nxt;
    logic              w_any, w_xfer, w_release, r_wr_en_q, r_err_drop, r_err_ovf;

    assign w_any     = |i_req_valid;
    assign w_gnt_inc = (r_gnt_id == IW'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
    // On release the search starts past the releasing producer, so it is considered last.
    assign w_from    = (r_state == GRANT) ? w_gnt_inc : r_ptr;
    assign w_rot     = {i_req_valid, i_req_valid} >> w_from;
    assign w_sum     = {1'b0, w_from} + {1'b0, w_off};
    assign w_pick    = (w_sum >= (IW+1)'(NUM_REQ)) ? IW'(w_sum - (IW+1)'(NUM_REQ)) : IW'(w_sum);

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (w_rot[k]) w_off = IW'(k);
    end

    assign w_xfer         = !rst && r_state == GRANT && i_req_valid[r_gnt_id] && !i_fifo_full;
    assign w_release      = r_state == GRANT && ((w_xfer && r_beats == BW'(MAX_BURST - 1)) || !i_req_valid[r_gnt_id]);
    assign o_req_ready    = (!rst && r_state == GRANT && !i_fifo_full) ? NUM_REQ'(1) << r_gnt_id : '0;
    assign o_fifo_wr_en   = w_xfer;
    assign o_fifo_data_in = i_req_data[r_gnt_id*FIFO_WIDTH +: FIFO_WIDTH];
    assign o_gnt_active   = r_state == GRANT;
    assign o_gnt_id       = r_gnt_id;
    assign o_err_drop     = r_err_drop;
    assign o_err_ovf      = r_err_ovf;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_id;
        w_ptr_nxt   = r_ptr;
        w_beats_nxt = r_beats;
        if (r_state == IDLE) begin
            if (w_any) begin
                w_state_nxt = GRANT;
                w_gnt_nxt   = w_pick;
                w_beats_nxt = '0;
            end
        end else if (w_release) begin
            w_ptr_nxt   = w_gnt_inc;
            w_state_nxt = w_any ? GRANT : IDLE;
            w_gnt_nxt   = w_any ? w_pick : r_gnt_id;
            w_beats_nxt = '0;
        end else if (w_xfer) begin
            w_beats_nxt = r_beats + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt_id   <= '0;
            r_ptr      <= '0;
            r_beats    <= '0;
            r_wr_en_q  <= 1'b0;
            r_err_drop <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_id   <= w_gnt_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beats    <= w_beats_nxt;
            r_wr_en_q  <= o_fifo_wr_en;
            r_err_drop <= (r_wr_en_q && !i_fifo_wr_ack) || (r_err_drop && !i_err_clr);
            r_err_ovf  <= i_fifo_overflow || (r_err_ovf && !i_err_clr);
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: random producers and FIFO status against a transaction-level arbiter model.
module tb_fifo_wr_arbiter;
    localparam int N = 4, W = 16, MB = 4, IW = 2;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, full, ack, ovf, eclr, wr_en, gact, edrop, eovf;
    logic [N-1:0] req_valid, req_ready;
    logic [N*W-1:0] req_data;
    logic [W-1:0] din;
    logic [IW-1:0] gid;
    int total = 0, bad = 0;
    bit m_act, m_wq, m_ed, m_eo;
    int m_gnt, m_ptr, m_beats, writes;
    bit pend [N];
    logic [W-1:0] pdata [N];

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
        .o_fifo_wr_en(wr_en), .o_fifo_data_in(din), .i_fifo_full(full), .i_fifo_wr_ack(ack),
        .i_fifo_overflow(ovf), .i_err_clr(eclr), .o_gnt_active(gact), .o_gnt_id(gid),
        .o_err_drop(edrop), .o_err_ovf(eovf));

    task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int from, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    task step(input bit r, input bit f, input bit o, input bit c, input bit sup, input logic [N-1:0] mask, input int vp);
        logic [N-1:0] v;
        bit ex, ack_now;
        int p, g;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && mask[i] && $urandom_range(0, 99) < vp) begin
                pend[i] = 1'b1;
                pdata[i] = W'($urandom);
            end
            req_valid[i] = pend[i];
            req_data[i*W +: W] = pdata[i];
        end
        rst = r; full = f; ovf = o; eclr = c;
        ack_now = m_wq && !sup;
        ack = ack_now;
        #1;
        ex = !r && m_act && pend[m_gnt] && !f;
        chk("wr_en", wr_en, ex);
        chk("ready", req_ready, (!r && m_act && !f) ? 64'(1) << m_gnt : 64'd0);
        chk("gnt_active", gact, m_act);
        chk("gnt_id", gid, m_gnt);
        chk("err_drop", edrop, m_ed);
        chk("err_ovf", eovf, m_eo);
        if (ex) chk("data", din, pdata[m_gnt]);
        @(posedge clk);
        v = req_valid;
        g = m_gnt;
        if (r) begin
            m_act = 0; m_gnt = 0; m_ptr = 0; m_beats = 0; m_wq = 0; m_ed = 0; m_eo = 0;
        end else begin
            m_ed = (m_wq && !ack_now) || (m_ed && !c);
            m_eo = o || (m_eo && !c);
            m_wq = ex;
            if (!m_act) begin
                p = pick(m_ptr, v);
                if (p >= 0) begin m_act = 1; m_gnt = p; m_beats = 0; end
            end else if ((ex && m_beats == MB - 1) || !v[m_gnt]) begin
                m_ptr = (m_gnt + 1) % N;
                p = pick(m_ptr, v);
                if (p >= 0) begin m_gnt = p; m_beats = 0; end
                else m_act = 0;
            end else if (ex) m_beats++;
            if (ex) begin pend[g] = 1'b0; writes++; end
        end
    endtask

    task run(input int n, input logic [N-1:0] mask, input int vp, input int fp, input int rp, input int sp, input int op, input int cp);
        for (int t = 0; t < n; t++)
            step($urandom_range(0, 99) < rp, $urandom_range(0, 99) < fp, $urandom_range(0, 99) < op,
                 $urandom_range(0, 99) < cp, $urandom_range(0, 99) < sp, mask, vp);
    endtask

    initial begin
        m_act = 0; m_gnt = 0; m_ptr = 0; m_beats = 0; m_wq = 0; m_ed = 0; m_eo = 0; writes = 0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; pdata[i] = '0; end
        rst = 1; full = 0; ack = 0; ovf = 0; eclr = 0; req_valid = '0; req_data = '0;
        @(posedge clk);
        step(1, 0, 0, 0, 0, 4'h0, 0);
        step(0, 0, 0, 0, 0, 4'h0, 0);
        run(8, 4'h1, 100, 0, 0, 0, 0, 0);
        run(4, 4'h0, 0, 0, 0, 0, 0, 0);
        run(24, 4'hF, 100, 0, 0, 0, 0, 0);
        for (int t = 0; t < 6; t++) step(0, t >= 2 && t < 5, 0, 0, 0, 4'hF, 100);
        run(6, 4'hC, 100, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'hF, 100);
        step(0, 0, 0, 0, 1, 4'hF, 100);
        run(4, 4'hF, 100, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 4'hF, 100);
        run(3, 4'hF, 100, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 4'hF, 100);
        step(0, 0, 0, 1, 0, 4'hF, 100);
        run(3, 4'hF, 100, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 4'hF, 100);
        run(4, 4'hF, 100, 0, 0, 0, 0, 0);
        run(600, 4'hF, 40, 25, 2, 5, 4, 8);
        run(300, 4'hF, 90, 10, 1, 3, 2, 5);
        chk("writes_seen", 64'(writes > 100), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
